// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the EXE-stage multiply/divide sequencer.
//   - data and multiplier operand widths
//   - op code encodings (OP_MUL_W .. OP_MOD_WU)
//   - FSM state encoding
//   - MUL_LAT default and DIV_CYCLES
//   - mul_ext: builds a 34-bit multiplier operand from a 32-bit source
package mdu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MOP_W      = XLEN + 2;
  localparam int unsigned MZ_W       = 2 * MOP_W;
  localparam int unsigned MUL_LAT    = 2;
  localparam int unsigned DIV_CYCLES = 32;

  localparam logic [2:0] OP_MUL_W   = 3'b000;
  localparam logic [2:0] OP_MULH_W  = 3'b001;
  localparam logic [2:0] OP_MULH_WU = 3'b010;
  localparam logic [2:0] OP_MUL_RSV = 3'b011;
  localparam logic [2:0] OP_DIV_W   = 3'b100;
  localparam logic [2:0] OP_MOD_W   = 3'b101;
  localparam logic [2:0] OP_DIV_WU  = 3'b110;
  localparam logic [2:0] OP_MOD_WU  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two-bit sign (or zero) extension for the 34-bit booth multiplier.
  function automatic logic [MOP_W-1:0] mul_ext(input logic [XLEN-1:0] v, input logic sgn);
    return {{2{v[XLEN-1] & sgn}}, v};
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// div_iter: restoring unsigned divider, one quotient bit per cycle, MSB first.
// Only compiled when MDU_DIV_EN is defined.
//   clk, reset            clock, asynchronous active-high reset
//   start                 load dividend/divisor; the first step runs on this edge
//   cancel                abort the division and clear the step counter
//   dividend, divisor     unsigned operands (sampled with start)
//   quotient, remainder   registered results, final when done is high
//   done                  one-cycle pulse after the last of DIV_CYCLES steps
`ifdef MDU_DIV_EN
module div_iter
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            cancel,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  logic [XLEN-1:0]  dsr;
  logic [CNT_W-1:0] cnt;
  logic             active;
  logic [XLEN-1:0]  rem_in, quo_in, dsr_in, rem_nxt, quo_nxt;
  logic [XLEN:0]    trial;

  // One restoring step; quotient register doubles as the dividend shifter.
  always_comb begin
    rem_in  = start ? '0 : remainder;
    quo_in  = start ? dividend : quotient;
    dsr_in  = start ? divisor : dsr;
    trial   = {rem_in, quo_in[XLEN-1]};
    rem_nxt = trial[XLEN-1:0];
    quo_nxt = {quo_in[XLEN-2:0], 1'b0};
    if (trial >= {1'b0, dsr_in}) begin
      rem_nxt    = XLEN'(trial - {1'b0, dsr_in});
      quo_nxt[0] = 1'b1;
    end
  end

  // Step sequencing: start performs step 1, the last step raises done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dsr       <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else if (cancel) begin
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient  <= quo_nxt;
        remainder <= rem_nxt;
        dsr       <= divisor;
        cnt       <= CNT_W'(1);
        active    <= 1'b1;
      end else if (active) begin
        quotient  <= quo_nxt;
        remainder <= rem_nxt;
        cnt       <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
          cnt    <= '0;
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer for the EXE stage.
// Multiplies use the external booth multiplier (mul_x/mul_y -> mul_z);
// divides use div_iter when MDU_DIV_EN is defined, otherwise div/mod ops
// complete immediately with result 0.
//   clk, reset                       clock, asynchronous active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_op, req_src1, req_src2       op code and operands
//   flush                            WB exception, cancels everything
//   mul_x, mul_y, mul_z              external multiplier operands / product
//   resp_valid/resp_ready            response handshake
//   resp_result                      registered result, held through DONE
//   busy                             controller not in IDLE
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic             flush,
  output logic [MOP_W-1:0] mul_x,
  output logic [MOP_W-1:0] mul_y,
  input  logic [MZ_W-1:0]  mul_z,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic             busy
);

  localparam int unsigned MCNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t            state, state_nxt;
  logic              accept;
  logic              mul_hi_r;
  logic [MCNT_W-1:0] mul_cnt;
  logic [XLEN-1:0]   mul_res;
  logic              req_mul_lo, req_mul_sgn;
  logic              unused_mz;

  // Product bits above 64 never contribute to a 32-bit result.
  assign unused_mz   = ^mul_z[MZ_W-1:2*XLEN];
  assign req_mul_lo  = (req_op == OP_MUL_W) || (req_op == OP_MUL_RSV);
  assign req_mul_sgn = (req_op != OP_MULH_WU);
  assign mul_res     = mul_hi_r ? mul_z[2*XLEN-1:XLEN] : mul_z[XLEN-1:0];

`ifdef MDU_DIV_EN
  logic            div_start, div_done, div_sgn;
  logic            q_neg_r, r_neg_r, is_mod_r;
  logic [XLEN-1:0] abs1, abs2, div_q, div_r, div_res;

  // Signed ops divide magnitudes; signs are restored on the way out.
  assign div_sgn   = (req_op == OP_DIV_W) || (req_op == OP_MOD_W);
  assign abs1      = (div_sgn && req_src1[XLEN-1]) ? XLEN'(-req_src1) : req_src1;
  assign abs2      = (div_sgn && req_src2[XLEN-1]) ? XLEN'(-req_src2) : req_src2;
  assign div_start = accept && req_op[2];
  assign div_res   = is_mod_r ? (r_neg_r ? XLEN'(-div_r) : div_r)
                              : (q_neg_r ? XLEN'(-div_q) : div_q);

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .cancel    (flush),
    .dividend  (abs1),
    .divisor   (abs2),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );
`endif

  // Next-state logic; flush overrides everything, including acceptance.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
`ifdef MDU_DIV_EN
          state_nxt = req_op[2] ? ST_DIV : ST_MUL;
`else
          state_nxt = req_op[2] ? ST_DONE : ST_MUL;
`endif
        end
      end
      ST_MUL: begin
        if (mul_cnt == MCNT_W'(MUL_CYCLES - 1)) state_nxt = ST_DONE;
      end
      ST_DIV: begin
`ifdef MDU_DIV_EN
        if (div_done) state_nxt = ST_DONE;
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (resp_valid && resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      accept    = 1'b0;
    end
  end

  // State register, registered handshake outputs and datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      mul_x       <= '0;
      mul_y       <= '0;
      mul_hi_r    <= 1'b0;
      mul_cnt     <= '0;
`ifdef MDU_DIV_EN
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      is_mod_r    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      req_ready  <= (state_nxt == ST_IDLE);
      busy       <= (state_nxt != ST_IDLE);
      resp_valid <= (state_nxt == ST_DONE);

      if (accept) begin
        mul_hi_r <= !req_mul_lo;
        mul_cnt  <= '0;
`ifdef MDU_DIV_EN
        // Divide by zero keeps the all-ones quotient un-negated.
        q_neg_r  <= div_sgn && (req_src1[XLEN-1] ^ req_src2[XLEN-1]) && (|req_src2);
        r_neg_r  <= div_sgn && req_src1[XLEN-1];
        is_mod_r <= req_op[0];
`endif
      end else if (state == ST_MUL) begin
        mul_cnt <= mul_cnt + MCNT_W'(1);
      end

      if (accept && state_nxt == ST_MUL) begin
        mul_x <= mul_ext(req_src1, req_mul_sgn);
        mul_y <= mul_ext(req_src2, req_mul_sgn);
      end else if (state_nxt != ST_MUL) begin
        mul_x <= '0;
        mul_y <= '0;
      end

      if (state == ST_MUL && state_nxt == ST_DONE) resp_result <= mul_res;
`ifdef MDU_DIV_EN
      if (state == ST_DIV && state_nxt == ST_DONE) resp_result <= div_res;
`else
      if (state == ST_IDLE && state_nxt == ST_DONE) resp_result <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl. Directed cases plus random
// ops compared against an arithmetic reference model; the external booth
// multiplier is modelled as a single register stage behind mul_x/mul_y.
// Works with or without MDU_DIV_EN defined.
module tb_mdu_ctrl;

`ifdef MDU_DIV_EN
  localparam int DIV_RESP = 33;
  localparam logic [2:0] FL_OP = 3'b100;
  localparam int FL_CYC = 10;
`else
  localparam int DIV_RESP = 1;
  localparam logic [2:0] FL_OP = 3'b000;
  localparam int FL_CYC = 2;
`endif
  localparam int MUL_RESP = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic [33:0] mul_x, mul_y;
  logic [67:0] mul_z = '0;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mdu_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .flush       (flush),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_z       (mul_z),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Booth multiplier stand-in: signed 34x34 product, one register stage.
  always @(posedge clk)
    mul_z <= $signed({{34{mul_x[33]}}, mul_x}) * $signed({{34{mul_y[33]}}, mul_y});

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint ps;
    longint unsigned pu;
    sa = int'(a);
    sb = int'(b);
    ps = longint'(sa) * longint'(sb);
    pu = {32'b0, a} * {32'b0, b};
    case (op)
      3'b000, 3'b011: return ps[31:0];
      3'b001:         return ps[63:32];
      3'b010:         return pu[63:32];
`ifdef MDU_DIV_EN
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      3'b110: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  // Issue one op at the current negedge (controller idle), follow it to
  // completion, hold off resp_ready for 'hold' cycles, end at the idle cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    logic [33:0] xe, ye;
    logic        sgn;
    int          lat, cyc;
    exp = model(op, a, b);
    lat = op[2] ? DIV_RESP : MUL_RESP;
    sgn = (op != 3'b010);
    xe  = op[2] ? 34'd0 : {{2{a[31] & sgn}}, a};
    ye  = op[2] ? 34'd0 : {{2{b[31] & sgn}}, b};
    check("req_ready_c0", 68'(req_ready), 68'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_src1   = a;
    req_src2   = b;
    resp_ready = (hold == 0);
    @(negedge clk);
    cyc       = 1;
    req_valid = 1'b0;
    req_src1  = $urandom;
    req_src2  = $urandom;
    check("busy_c1", 68'(busy), 68'd1);
    check("req_ready_c1", 68'(req_ready), 68'd0);
    check("mul_x_c1", 68'(mul_x), 68'(xe));
    check("mul_y_c1", 68'(mul_y), 68'(ye));
    while (resp_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency_op%0d", op), 68'(cyc), 68'(lat));
    check($sformatf("result_op%0d_%0h_%0h", op, a, b), 68'(resp_result), 68'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 68'(resp_valid), 68'd1);
      check("hold_result", 68'(resp_result), 68'(exp));
      check("hold_req_ready", 68'(req_ready), 68'd0);
      check("hold_busy", 68'(busy), 68'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("idle_valid", 68'(resp_valid), 68'd0);
    check("idle_req_ready", 68'(req_ready), 68'd1);
    check("idle_busy", 68'(busy), 68'd0);
    resp_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corner [5];
    corner[0] = 32'd0;
    corner[1] = 32'd1;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic seen;
    int   cyc;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'b000;
    req_src1   = '0;
    req_src2   = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;

    @(negedge clk);
    check("rst_req_ready", 68'(req_ready), 68'd1);
    check("rst_busy", 68'(busy), 68'd0);
    check("rst_resp_valid", 68'(resp_valid), 68'd0);
    check("rst_resp_result", 68'(resp_result), 68'd0);
    check("rst_mul_x", 68'(mul_x), 68'd0);
    check("rst_mul_y", 68'(mul_y), 68'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'b011, 32'h0001_2345, 32'h0000_0678, 1);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'b110, 32'd100, 32'd0, 0);
    run_op(3'b111, 32'd100, 32'd0, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'b100, 32'd10, 32'd3, 5);

    // Flush in the same cycle as a request: nothing is accepted.
    req_valid  = 1'b1;
    req_op     = 3'b000;
    req_src1   = 32'd3;
    req_src2   = 32'd4;
    flush      = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flush_acc_busy", 68'(busy), 68'd0);
    check("flush_acc_ready", 68'(req_ready), 68'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= resp_valid;
      @(negedge clk);
    end
    check("flush_acc_no_resp", 68'(seen), 68'd0);

    // Flush in the middle of an operation, then a mul right behind it.
    req_valid = 1'b1;
    req_op    = FL_OP;
    req_src1  = 32'd1000;
    req_src2  = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    cyc       = 1;
    seen      = 1'b0;
    while (cyc < FL_CYC) begin
      seen |= resp_valid;
      @(negedge clk);
      cyc++;
    end
    seen |= resp_valid;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_no_resp", 68'(seen), 68'd0);
    check("flush_resp_valid", 68'(resp_valid), 68'd0);
    check("flush_busy", 68'(busy), 68'd0);
    check("flush_req_ready", 68'(req_ready), 68'd1);
    run_op(3'b000, 32'h0000_1234, 32'h0000_0010, 0);

    // Asynchronous reset while a result is being held.
    req_valid  = 1'b1;
    req_op     = 3'b000;
    req_src1   = 32'd5;
    req_src2   = 32'd5;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_valid", 68'(resp_valid), 68'd1);
    check("pre_reset_result", 68'(resp_result), 68'd25);
    reset = 1'b1;
    #1;
    check("async_rst_valid", 68'(resp_valid), 68'd0);
    check("async_rst_result", 68'(resp_result), 68'd0);
    check("async_rst_busy", 68'(busy), 68'd0);
    check("async_rst_ready", 68'(req_ready), 68'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Random ops against the reference model
    for (int n = 0; n < 30; n++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
